aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller.
- Accepts one plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey.
- Drives the shared intermediate-round datapath (SubBytes, ShiftRows, MixColumns, key expansion, AddRoundKey) for rounds 1..9, then a final round without MixColumns.
- Presents the ciphertext on a valid/ready output. It sits between the host interface and the round datapath, and holds all state registers and round sequencing.

Parameters:
- NR, 10, number of AES rounds; only 10 (AES-128) is supported, and elaboration fails otherwise.
- CLEAR_ON_IDLE, 1, when 1, state/key/ciphertext registers are zeroed on return to IDLE.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  plaintext/key pair presented
- in_ready  output  1  sequencer can accept a new block
- in_plaintext  input  128  plaintext, byte 0 in bits [127:120]
- in_key  input  128  cipher key, same byte order
- out_valid  output  1  ciphertext available
- out_ready  input  1  consumer accepts ciphertext
- out_ciphertext  output  128  result, same byte order
- busy  output  1  high while in RUN
- round_idx  output  4  current round number (0 in IDLE/DONE)

Behaviour:
- Reset is asynchronous, active-low. It applies immediately, including mid-encryption, and discards the block in flight.
  - FSM goes to IDLE; state_reg, key_reg and out_ciphertext are 0.
  - in_ready=1 after reset release; out_valid=0, busy=0, round_idx=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_reg <= in_plaintext ^ in_key; key_reg <= in_key; round_idx <= 1; go to RUN.
- RUN (in_ready=0, busy=1):
  - The datapath receives rc=round_idx, stateMatrix=state_reg, in_key=key_reg.
  - If round_idx < NR: state_reg <= round_out; key_reg <= out_key; round_idx <= round_idx+1.
  - If round_idx == NR: out_ciphertext <= final_out, where final_out = ShiftRows(SubBytes(state_reg)) ^ round key 10. out_valid <= 1; round_idx <= 0; go to DONE.
- DONE:
  - out_valid=1; out_ciphertext is held stable until out_ready.
  - On out_ready: out_valid <= 0; go to IDLE.
  - If CLEAR_ON_IDLE=1, state_reg, key_reg and out_ciphertext <= 0 in that same edge.
- in_ready is low in RUN and DONE, so a new block cannot be accepted in the same cycle as the output handshake.
- Latency: the accept edge is edge 0; out_valid rises at edge 10. Minimum accept-to-accept interval is 12 cycles when out_ready is held high.
- Inputs are sampled only at the accept edge. in_plaintext/in_key may change freely afterwards.
- out_ready asserted while not in DONE is ignored. in_valid while not in IDLE is ignored and the source must hold it.
- One round per clock, purely combinational between registers. The round key is derived from key_reg and rc each cycle; no key schedule is stored.
- rc encoding: round number 1..10. The key-expansion Rcon lookup is indexed by it.

Decomposition:
- Shared package aes_pkg:
  - NR_AES128=10.
  - State enum {IDLE, RUN, DONE}.
  - 128-bit block typedef.
  - FIPS-197 test-vector constants for benches.
- The existing Round module is instantiated once for rounds 1..9.
- One natural sub-module, aes_final_round (rc, stateMatrix, in_key -> final_out): key generation + subbytes + shiftrow + AddRoundKey, no mixcolumn. It reuses the existing key-generation, subbytes and shiftrow blocks.
- The sequencer itself holds only the FSM, registers and muxing.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready=1 -> out_valid exactly 10 cycles after accept, ct 3925841d02dc09fbdc118597196a0b32, then in_ready=1 the next cycle.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a; round_idx steps 1..10 then 0.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> ciphertext stable, in_ready=0 throughout; a second in_valid is not accepted until 1 cycle after the out handshake.
- Input change after accept: drive App. B then swap in_plaintext/in_key to random values on the next cycle -> result still 3925841d....
- Reset mid-op: assert reset_n=0 at round 5 -> out_valid=0, busy=0, round_idx=0, in_ready=1 immediately; a subsequent App. C.1 run gives the correct ct.
- Back-to-back: 4 random blocks, out_ready=1, checked against a reference model -> all match, accept interval 12 cycles, and registers read 0 in IDLE when CLEAR_ON_IDLE=1.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, constants and the round-level transforms
// (SubBytes, ShiftRows, MixColumns, key expansion) used by the round blocks.
package aes_pkg;
    localparam int NR_AES128 = 10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
    typedef logic [127:0] block_t;

    localparam block_t FIPS_B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam block_t FIPS_B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam block_t FIPS_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam block_t FIPS_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t FIPS_C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam block_t FIPS_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, v;
        p = x;
        v = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            v = gf_mul(v, p);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(w[8*i +: 8]);
        return r;
    endfunction

    function automatic block_t sub_bytes(input block_t b);
        block_t r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(b[8*i +: 8]);
        return r;
    endfunction

    // byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4
    function automatic block_t shift_rows(input block_t b);
        block_t r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = b[127-8*(4*((c+w)%4)+w) -: 8];
        return r;
    endfunction

    function automatic block_t mix_columns(input block_t b);
        block_t r;
        logic [7:0] a [4];
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) a[w] = b[127-8*(4*c+w) -: 8];
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = xtime(a[w]) ^ xtime(a[(w+1)%4]) ^ a[(w+1)%4]
                                        ^ a[(w+2)%4] ^ a[(w+3)%4];
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < 10; i++) if (4'(i) < rc) r = xtime(r);
        return r;
    endfunction

    function automatic block_t key_expand(input block_t k, input logic [3:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(rc), 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction
endpackage

// File: rtl/aes_final_round.sv
// aes_final_round: last AES round, identical to a full round minus MixColumns.
module aes_final_round
    import aes_pkg::*;
(
    input  logic [3:0] rc,
    input  block_t     state_matrix,
    input  block_t     in_key,
    output block_t     final_out
);
    assign final_out = shift_rows(sub_bytes(state_matrix)) ^ key_expand(in_key, rc);
endmodule

// File: rtl/aes_round.sv
// aes_round: one full AES round (rounds 1..9) plus next round key from rc.
module aes_round
    import aes_pkg::*;
(
    input  logic [3:0] rc,
    input  block_t     state_matrix,
    input  block_t     in_key,
    output block_t     round_out,
    output block_t     out_key
);
    assign out_key   = key_expand(in_key, rc);
    assign round_out = mix_columns(shift_rows(sub_bytes(state_matrix))) ^ out_key;
endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryptor, one round per clock,
// with valid/ready handshakes on both the block input and the ciphertext output.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR            = 10,
    parameter bit CLEAR_ON_IDLE = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_plaintext,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_ciphertext,
    output logic         busy,
    output logic [3:0]   round_idx
);
    if (NR != NR_AES128) begin : g_nr_check
        $error("aes_round_sequencer supports only NR=10 (AES-128)");
    end

    fsm_t   state, next;
    block_t state_reg, key_reg, round_out, out_key, final_out;
    logic   last;

    assign last = round_idx == 4'(NR);

    aes_round u_round (
        .rc           (round_idx),
        .state_matrix (state_reg),
        .in_key       (key_reg),
        .round_out    (round_out),
        .out_key      (out_key)
    );

    aes_final_round u_final (
        .rc           (round_idx),
        .state_matrix (state_reg),
        .in_key       (key_reg),
        .final_out    (final_out)
    );

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= next;

    always_comb begin
        next = state == IDLE ? (in_valid ? RUN : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : state == DONE ? (out_ready ? IDLE : DONE)
             : IDLE;
    end

    always_comb begin
        in_ready  = state == IDLE;
        busy      = state == RUN;
        out_valid = state == DONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= '0;
            key_reg        <= '0;
            out_ciphertext <= '0;
            round_idx      <= '0;
        end else if (state == IDLE && in_valid) begin
            state_reg <= in_plaintext ^ in_key;
            key_reg   <= in_key;
            round_idx <= 4'd1;
        end else if (state == RUN && !last) begin
            state_reg <= round_out;
            key_reg   <= out_key;
            round_idx <= round_idx + 4'd1;
        end else if (state == RUN) begin
            out_ciphertext <= final_out;
            round_idx      <= '0;
        end else if (state == DONE && out_ready && CLEAR_ON_IDLE) begin
            state_reg      <= '0;
            key_reg        <= '0;
            out_ciphertext <= '0;
        end
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed checks of the AES-128 sequencer against
// FIPS-197 vectors and an independent table-driven reference model.
module tb_aes_round_sequencer;
    import aes_pkg::*;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_plaintext;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_ciphertext;
    logic         busy;
    logic [3:0]   round_idx;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int n, prev_acc, acc;
    logic [127:0] exp_ct;
    logic [7:0]   sb [256];

    aes_round_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_plaintext   (in_plaintext),
        .in_key         (in_key),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ciphertext (out_ciphertext),
        .busy           (busy),
        .round_idx      (round_idx)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out();
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // S-box by walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] dbl(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = dbl(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sb[s[(k%4) + 4*(((k/4) + (k%4)) % 4)]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    s[4*c+j] = (r == 10) ? t[4*c+j]
                             : dbl(t[4*c+j]) ^ dbl(t[4*c+(j+1)%4]) ^ t[4*c+(j+1)%4]
                               ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
        return o;
    endfunction

    initial begin
        build_sbox();
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_plaintext = '0;
        in_key       = '0;
        #3;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        checkn("rst_round_idx", int'(round_idx), 0);
        check("rst_ct", out_ciphertext, '0);
        #20 reset_n = 1'b1;
        tick();

        // App. B with inputs scrambled right after accept
        in_plaintext = FIPS_B_PT;
        in_key       = FIPS_B_KEY;
        in_valid     = 1'b1;
        out_ready    = 1'b1;
        tick();
        in_valid     = 1'b0;
        in_plaintext = {$urandom, $urandom, $urandom, $urandom};
        in_key       = {$urandom, $urandom, $urandom, $urandom};
        check1("b_busy", busy, 1'b1);
        check1("b_in_ready_low", in_ready, 1'b0);
        checkn("b_round1", int'(round_idx), 1);
        wait_out();
        checkn("b_latency", n, 10);
        check("b_ct", out_ciphertext, FIPS_B_CT);
        tick();
        check1("b_in_ready_after", in_ready, 1'b1);
        check1("b_out_valid_after", out_valid, 1'b0);
        check("b_ct_cleared", out_ciphertext, '0);

        // App. C.1 with round stepping, then 20 cycles of backpressure
        in_plaintext = FIPS_C1_PT;
        in_key       = FIPS_C1_KEY;
        in_valid     = 1'b1;
        out_ready    = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            checkn("c1_round_idx", int'(round_idx), r);
            tick();
        end
        checkn("c1_round_idx_done", int'(round_idx), 0);
        check1("c1_out_valid", out_valid, 1'b1);
        check("c1_ct", out_ciphertext, FIPS_C1_CT);
        in_plaintext = FIPS_B_PT;
        in_key       = FIPS_B_KEY;
        in_valid     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_ct_stable", out_ciphertext, FIPS_C1_CT);
            check1("bp_in_ready", in_ready, 1'b0);
            check1("bp_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        check1("bp_handshake_idle", in_ready, 1'b1);
        check1("bp_handshake_busy", busy, 1'b0);
        check1("bp_handshake_ov", out_valid, 1'b0);
        tick();
        in_valid = 1'b0;
        check1("bp_second_busy", busy, 1'b1);
        checkn("bp_second_round", int'(round_idx), 1);
        wait_out();
        checkn("bp_second_latency", n, 10);
        check("bp_second_ct", out_ciphertext, FIPS_B_CT);
        tick();

        // asynchronous reset during round 5
        in_plaintext = FIPS_B_PT;
        in_key       = FIPS_B_KEY;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        checkn("mid_round5", int'(round_idx), 5);
        #2 reset_n = 1'b0;
        #1;
        check1("mid_out_valid", out_valid, 1'b0);
        check1("mid_busy", busy, 1'b0);
        checkn("mid_round_idx", int'(round_idx), 0);
        check1("mid_in_ready", in_ready, 1'b1);
        check("mid_state_reg", dut.state_reg, '0);
        check("mid_key_reg", dut.key_reg, '0);
        #2 reset_n = 1'b1;
        in_plaintext = FIPS_C1_PT;
        in_key       = FIPS_C1_KEY;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out();
        checkn("post_rst_latency", n, 10);
        check("post_rst_ct", out_ciphertext, FIPS_C1_CT);
        tick();

        // back-to-back random blocks against the reference model
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_plaintext = {$urandom, $urandom, $urandom, $urandom};
            in_key       = {$urandom, $urandom, $urandom, $urandom};
            exp_ct       = ref_aes(in_plaintext, in_key);
            in_valid     = 1'b1;
            check1("b2b_ready", in_ready, 1'b1);
            tick();
            acc      = cyc;
            in_valid = 1'b0;
            if (i > 0) checkn("b2b_interval", acc - prev_acc, 12);
            prev_acc = acc;
            wait_out();
            checkn("b2b_latency", n, 10);
            check("b2b_ct", out_ciphertext, exp_ct);
            tick();
            check("b2b_idle_ct", out_ciphertext, '0);
            check("b2b_idle_state", dut.state_reg, '0);
            check("b2b_idle_key", dut.key_reg, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
